// File: rtl/step_pkg.sv
// Shared FSM state encoding for the step pulse generator.
package step_pkg;

    localparam int STATE_W = 2;

    // Encoding 3 is deliberately absent; the FSM treats it as a fault and returns to MANUAL.
    typedef enum logic [STATE_W-1:0] {
        MANUAL    = 2'd0,
        AUTO_RUN  = 2'd1,
        AUTO_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/debouncer.sv
// Two-flop synchroniser followed by a stability counter.
// dout follows din only after the synchronised input has disagreed with dout for DB_CYCLES cycles in a row.
module debouncer #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            cnt  <= '0;
            dout <= 1'b0;
        end else begin
            sync <= {sync[0], din};
            // Any cycle of agreement restarts the count from zero.
            if (sync[1] == dout) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                dout <= sync[1];
                cnt  <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/step_pulse_gen.sv
// Advance-strobe generator: a debounced button gives single steps in manual mode
// and pauses/resumes a free-running prescaler in auto mode.
module step_pulse_gen
    import step_pkg::*;
#(
    parameter int DB_CYCLES = 1_000_000,
    parameter int STEP_DIV  = 100_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_step,
    input  logic               mode_auto,
    output logic               step_pulse,
    output logic               btn_clean,
    output logic [STATE_W-1:0] state
);

    localparam int PS_W = $clog2(STEP_DIV);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(STEP_DIV - 1);

    logic [1:0]      mode_sync;
    logic            mode_on;
    logic            btn_clean_d;
    logic            btn_rise;
    state_t          state_q;
    state_t          state_d;
    logic [PS_W-1:0] prescaler;
    logic [PS_W-1:0] prescaler_d;
    logic            pulse_d;

    debouncer #(
        .DB_CYCLES(DB_CYCLES)
    ) u_btn_db (
        .clk  (clk),
        .rst  (rst),
        .din  (btn_step),
        .dout (btn_clean)
    );

    assign mode_on  = mode_sync[1];
    assign btn_rise = btn_clean & ~btn_clean_d;
    assign state    = state_q;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        prescaler_d = prescaler;
        pulse_d     = 1'b0;
        case (state_q)
            MANUAL: begin
                prescaler_d = '0;
                if (mode_on) state_d = AUTO_RUN;
                else         pulse_d = btn_rise;
            end
            AUTO_RUN: begin
                prescaler_d = (prescaler == PS_LAST) ? '0 : prescaler + PS_W'(1);
                // Leaving auto mode beats a press, and a press beats the terminal-count pulse.
                if (!mode_on)      state_d = MANUAL;
                else if (btn_rise) state_d = AUTO_HOLD;
                else               pulse_d = (prescaler == PS_LAST);
            end
            AUTO_HOLD: begin
                if (!mode_on)      state_d = MANUAL;
                else if (btn_rise) state_d = AUTO_RUN;
            end
            default: begin
                state_d     = MANUAL;
                prescaler_d = '0;
            end
        endcase
        if (step_pulse) pulse_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_sync   <= '0;
            btn_clean_d <= 1'b0;
            state_q     <= MANUAL;
            prescaler   <= '0;
            step_pulse  <= 1'b0;
        end else begin
            mode_sync   <= {mode_sync[0], mode_auto};
            btn_clean_d <= btn_clean;
            state_q     <= state_d;
            prescaler   <= prescaler_d;
            step_pulse  <= pulse_d;
        end
    end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Self-checking bench for step_pulse_gen with DB_CYCLES=4, STEP_DIV=5:
// a vector table, hand-timed corner sequences, then random stimulus against a reference model.
module tb_step_pulse_gen;

    localparam int DB  = 4;
    localparam int DIV = 5;
    localparam int M_MANUAL = 0;
    localparam int M_RUN    = 1;
    localparam int M_HOLD   = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_step;
    logic       mode_auto;
    logic       step_pulse;
    logic       btn_clean;
    logic [1:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    step_pulse_gen #(
        .DB_CYCLES(DB),
        .STEP_DIV (DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_step   (btn_step),
        .mode_auto  (mode_auto),
        .step_pulse (step_pulse),
        .btn_clean  (btn_clean),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: synchroniser delay, run-length debounce, and a step phase counted modulo DIV.
    int m_b1, m_b2, m_m1, m_m2;
    int m_clean, m_clean_prev, m_run;
    int m_mode, m_phase, m_pulse;
    bit model_on = 1'b0;

    always @(posedge clk) begin
        int rise, auto_on, terminal, next_pulse;
        if (rst) begin
            m_b1 = 0; m_b2 = 0; m_m1 = 0; m_m2 = 0;
            m_clean = 0; m_clean_prev = 0; m_run = 0;
            m_mode = M_MANUAL; m_phase = 0; m_pulse = 0;
        end else begin
            rise       = (m_clean == 1 && m_clean_prev == 0) ? 1 : 0;
            auto_on    = m_m2;
            next_pulse = 0;
            case (m_mode)
                M_MANUAL: begin
                    if (auto_on == 1) begin m_mode = M_RUN; m_phase = 0; end
                    else if (rise == 1) next_pulse = 1;
                end
                M_RUN: begin
                    terminal = (m_phase == DIV - 1) ? 1 : 0;
                    m_phase  = (m_phase + 1) % DIV;
                    if (auto_on == 0)      m_mode = M_MANUAL;
                    else if (rise == 1)    m_mode = M_HOLD;
                    else if (terminal == 1) next_pulse = 1;
                end
                default: begin
                    if (auto_on == 0)   m_mode = M_MANUAL;
                    else if (rise == 1) m_mode = M_RUN;
                end
            endcase
            m_pulse      = next_pulse;
            m_clean_prev = m_clean;
            if (m_b2 != m_clean) begin
                m_run++;
                if (m_run == DB) begin m_clean = m_b2; m_run = 0; end
            end else begin
                m_run = 0;
            end
            m_b2 = m_b1; m_b1 = int'(btn_step);
            m_m2 = m_m1; m_m1 = int'(mode_auto);
        end
    end

    int pulses_seen = 0;
    logic prev_pulse = 1'b0;

    always @(negedge clk) begin
        if (model_on) begin
            check("model_pulse", step_pulse, m_pulse);
            check("model_clean", btn_clean, m_clean);
            check("model_state", state, m_mode);
            if (step_pulse === 1'b1 && prev_pulse === 1'b1)
                check("no_back_to_back", 1, 0);
            if (step_pulse === 1'b1) pulses_seen++;
            prev_pulse = step_pulse;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, input string name);
        int n = 0;
        while (state !== s && n < budget) begin
            cyc(1);
            n++;
        end
        check(name, state, s);
    endtask

    typedef struct {
        logic       rst;
        logic       btn;
        logic       mode;
        logic       pulse;
        logic       clean;
        logic [1:0] st;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(logic r, logic b, logic m, logic p, logic c, logic [1:0] s);
        vec_t v;
        v.rst = r; v.btn = b; v.mode = m; v.pulse = p; v.clean = c; v.st = s;
        return v;
    endfunction

    initial begin
        int p0;
        rst = 1'b1; btn_step = 1'b0; mode_auto = 1'b0;

        // Clean press/release in MANUAL, then a brief excursion into AUTO_RUN.
        vecs[0] = mk(1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) vecs[i] = mk(0, 1, 0, 0, 0, 0);
        vecs[6] = mk(0, 1, 0, 0, 1, 0);
        vecs[7] = mk(0, 1, 0, 1, 1, 0);
        vecs[8] = mk(0, 1, 0, 0, 1, 0);
        for (int i = 9; i <= 13; i++) vecs[i] = mk(0, 0, 0, 0, 1, 0);
        vecs[14] = mk(0, 0, 0, 0, 0, 0);
        vecs[15] = mk(0, 0, 0, 0, 0, 0);
        vecs[16] = mk(0, 0, 1, 0, 0, 0);
        vecs[17] = mk(0, 0, 1, 0, 0, 0);
        vecs[18] = mk(0, 0, 1, 0, 0, 1);
        vecs[19] = mk(0, 0, 0, 0, 0, 1);
        vecs[20] = mk(0, 0, 0, 0, 0, 1);
        vecs[21] = mk(0, 0, 0, 0, 0, 0);

        @(negedge clk);
        for (int i = 0; i < 22; i++) begin
            rst = vecs[i].rst; btn_step = vecs[i].btn; mode_auto = vecs[i].mode;
            cyc(1);
            check($sformatf("vec%0d_pulse", i), step_pulse, vecs[i].pulse);
            check($sformatf("vec%0d_clean", i), btn_clean, vecs[i].clean);
            check($sformatf("vec%0d_state", i), state, vecs[i].st);
            if (i == 0) model_on = 1'b1;
        end

        // Bounce: toggle every 2 clks for 20 clks, then hold -> a single pulse.
        p0 = pulses_seen;
        for (int k = 0; k < 10; k++) begin
            btn_step = (k % 2 == 0);
            cyc(2);
        end
        btn_step = 1'b1;
        check("bounce_quiet", pulses_seen - p0, 0);
        cyc(12);
        check("bounce_one_pulse", pulses_seen - p0, 1);
        btn_step = 1'b0;
        cyc(10);

        // Auto run: pulse on every 5th clk after entering AUTO_RUN.
        mode_auto = 1'b1;
        wait_state(2'd1, 10, "auto_enter");
        p0 = pulses_seen;
        for (int k = 1; k <= 23; k++) begin
            cyc(1);
            check($sformatf("auto_pulse_%0d", k), step_pulse, (k % 5 == 0));
        end
        check("auto_pulse_count", pulses_seen - p0, 4);
        mode_auto = 1'b0;
        wait_state(2'd0, 10, "auto_exit");

        // Pause with the prescaler landing on 2, then resume: first pulse 3 clks later.
        mode_auto = 1'b1;
        wait_state(2'd1, 10, "pause_enter");
        btn_step = 1'b1;
        cyc(7);
        check("pause_state", state, 2'd2);
        p0 = pulses_seen;
        cyc(4);
        btn_step = 1'b0;
        cyc(10);
        check("pause_no_pulse", pulses_seen - p0, 0);
        check("pause_still_hold", state, 2'd2);
        btn_step = 1'b1;
        wait_state(2'd1, 12, "resume_state");
        cyc(1); check("resume_t1", step_pulse, 0);
        cyc(1); check("resume_t2", step_pulse, 0);
        cyc(1); check("resume_t3", step_pulse, 1);
        btn_step = 1'b0; mode_auto = 1'b0;
        wait_state(2'd0, 10, "resume_exit");
        cyc(8);

        // Press lands on the terminal count: pause wins and the prescaler wraps to 0.
        mode_auto = 1'b1;
        wait_state(2'd1, 10, "coinc_enter");
        cyc(3);
        btn_step = 1'b1;
        cyc(2);
        check("coinc_regular_pulse", step_pulse, 1);
        cyc(5);
        check("coinc_state", state, 2'd2);
        check("coinc_suppressed", step_pulse, 0);
        btn_step = 1'b0;
        cyc(8);
        btn_step = 1'b1;
        wait_state(2'd1, 12, "coinc_resume");
        for (int k = 1; k <= 5; k++) begin
            cyc(1);
            check($sformatf("coinc_resume_t%0d", k), step_pulse, (k == 5));
        end
        btn_step = 1'b0; mode_auto = 1'b0;
        wait_state(2'd0, 10, "coinc_exit");
        cyc(8);

        // Reset in AUTO_RUN at prescaler 3 with the button held.
        btn_step = 1'b1;
        cyc(8);
        check("rst_pre_clean", btn_clean, 1);
        mode_auto = 1'b1;
        wait_state(2'd1, 10, "rst_enter");
        cyc(3);
        rst = 1'b1; mode_auto = 1'b0;
        cyc(1);
        check("rst_state", state, 2'd0);
        check("rst_pulse", step_pulse, 0);
        check("rst_clean", btn_clean, 0);
        rst = 1'b0;
        cyc(1);
        check("rst_no_pulse_after", step_pulse, 0);
        cyc(4);
        check("rst_redebounce_pending", btn_clean, 0);
        cyc(1);
        check("rst_redebounce_done", btn_clean, 1);
        cyc(1);
        check("rst_manual_pulse", step_pulse, 1);
        btn_step = 1'b0;
        cyc(10);

        // Random stimulus checked cycle by cycle against the model.
        for (int seg = 0; seg < 400; seg++) begin
            btn_step = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) mode_auto = ~mode_auto;
            rst = ($urandom_range(0, 63) == 0);
            cyc(1);
            rst = 1'b0;
            cyc($urandom_range(1, 12));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
